// File: rtl/banco_reg_param.sv
// Parametrised register file: two combinational read ports and one synchronous
// write port. Adds synchronous clear, optional write-to-read bypass, an optional
// hard-wired zero register, and a per-register busy scoreboard.
module banco_reg_param #(
    parameter int unsigned LARGURA = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         Read1,
    input  logic [ADDR_W-1:0]         Read2,
    input  logic [ADDR_W-1:0]         WriteReg,
    input  logic [LARGURA-1:0]        WriteData,
    input  logic                      RegWrite,
    input  logic                      Reserve,
    input  logic [ADDR_W-1:0]         ReserveReg,
    output logic [LARGURA-1:0]        Data1,
    output logic [LARGURA-1:0]        Data2,
    output logic                      Pending1,
    output logic                      Pending2,
    output logic [(1<<ADDR_W)-1:0]    Busy
);

    localparam int unsigned NUM_REGS   = 1 << ADDR_W;
    localparam bit          HAS_BYPASS = (BYPASS != 0);
    localparam bit          HAS_ZERO   = (ZERO_R0 != 0);

    logic [LARGURA-1:0]  mem_q [NUM_REGS];
    logic [LARGURA-1:0]  mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic wr_en_c;
    logic res_en_c;
    logic hit1_c;
    logic hit2_c;

    // Writes and reservations aimed at a hard-wired zero register are dropped.
    always_comb begin
        wr_en_c  = RegWrite && !(HAS_ZERO && (WriteReg == '0));
        res_en_c = Reserve  && !(HAS_ZERO && (ReserveReg == '0));
    end

    // Next-state for storage and scoreboard; a reservation beats a same-cycle writeback.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_en_c) begin
            mem_d[WriteReg] = WriteData;
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (res_en_c && (ReserveReg == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (RegWrite && (WriteReg == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // State registers with synchronous clear; reset drops any in-flight write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    // Bypass hit detection: only a committed (non-suppressed) write outside reset forwards.
    always_comb begin
        hit1_c = HAS_BYPASS && !reset && wr_en_c && (WriteReg == Read1);
        hit2_c = HAS_BYPASS && !reset && wr_en_c && (WriteReg == Read2);
    end

    // Read port 1.
    always_comb begin
        Data1    = hit1_c ? WriteData : mem_q[Read1];
        Pending1 = busy_q[Read1] && !hit1_c;
        if (HAS_ZERO && (Read1 == '0)) begin
            Data1    = '0;
            Pending1 = 1'b0;
        end
    end

    // Read port 2.
    always_comb begin
        Data2    = hit2_c ? WriteData : mem_q[Read2];
        Pending2 = busy_q[Read2] && !hit2_c;
        if (HAS_ZERO && (Read2 == '0)) begin
            Data2    = '0;
            Pending2 = 1'b0;
        end
    end

    assign Busy = busy_q;

endmodule

// File: tb/tb_banco_reg_param.sv
// Bench for banco_reg_param: default, no-bypass, zero-register and 32x16 instances.
module tb_banco_reg_param;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the three 16-bit / 8-register instances.
    logic        rst, we, res;
    logic [2:0]  wreg, rreg, r1, r2;
    logic [15:0] wd;

    logic [15:0] a_d1, a_d2, b_d1, b_d2, z_d1, z_d2;
    logic        a_p1, a_p2, b_p1, b_p2, z_p1, z_p2;
    logic [7:0]  a_busy, b_busy, z_busy;

    // Stimulus for the 32-bit / 16-register instance.
    logic        w_rst, w_we, w_res;
    logic [3:0]  w_wreg, w_rreg, w_r1, w_r2;
    logic [31:0] w_wd, w_d1, w_d2;
    logic        w_p1, w_p2;
    logic [15:0] w_busy;

    banco_reg_param #(.LARGURA(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) u_a (
        .clock(clk), .reset(rst), .Read1(r1), .Read2(r2), .WriteReg(wreg),
        .WriteData(wd), .RegWrite(we), .Reserve(res), .ReserveReg(rreg),
        .Data1(a_d1), .Data2(a_d2), .Pending1(a_p1), .Pending2(a_p2), .Busy(a_busy));

    banco_reg_param #(.LARGURA(16), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) u_b (
        .clock(clk), .reset(rst), .Read1(r1), .Read2(r2), .WriteReg(wreg),
        .WriteData(wd), .RegWrite(we), .Reserve(res), .ReserveReg(rreg),
        .Data1(b_d1), .Data2(b_d2), .Pending1(b_p1), .Pending2(b_p2), .Busy(b_busy));

    banco_reg_param #(.LARGURA(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) u_z (
        .clock(clk), .reset(rst), .Read1(r1), .Read2(r2), .WriteReg(wreg),
        .WriteData(wd), .RegWrite(we), .Reserve(res), .ReserveReg(rreg),
        .Data1(z_d1), .Data2(z_d2), .Pending1(z_p1), .Pending2(z_p2), .Busy(z_busy));

    banco_reg_param #(.LARGURA(32), .ADDR_W(4), .BYPASS(1), .ZERO_R0(0)) u_w (
        .clock(clk), .reset(w_rst), .Read1(w_r1), .Read2(w_r2), .WriteReg(w_wreg),
        .WriteData(w_wd), .RegWrite(w_we), .Reserve(w_res), .ReserveReg(w_rreg),
        .Data1(w_d1), .Data2(w_d2), .Pending1(w_p1), .Pending2(w_p2), .Busy(w_busy));

    typedef enum int {
        A_D1, A_D2, A_P1, A_P2, A_BUSY,
        B_D1, B_P1, B_BUSY,
        Z_D1, Z_P1, Z_BUSY,
        W_D1, W_D2, W_BUSY
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    typedef struct {
        logic        rst, we;
        logic [2:0]  wreg;
        logic [15:0] wd;
        logic        res;
        logic [2:0]  rreg, r1, r2;
        logic [15:0] d1, d2;
        logic        p1, p2;
        logic [7:0]  busy;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[21];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic vrst, logic vwe, logic [2:0] vwreg, logic [15:0] vwd,
                                logic vres, logic [2:0] vrreg, logic [2:0] vr1, logic [2:0] vr2,
                                logic [15:0] vd1, logic [15:0] vd2, logic vp1, logic vp2,
                                logic [7:0] vbusy);
        vec_t v;
        v.rst = vrst; v.we = vwe; v.wreg = vwreg; v.wd = vwd;
        v.res = vres; v.rreg = vrreg; v.r1 = vr1; v.r2 = vr2;
        v.d1 = vd1; v.d2 = vd2; v.p1 = vp1; v.p2 = vp2; v.busy = vbusy;
        return v;
    endfunction

    function automatic logic [31:0] actual(sig_e s);
        case (s)
            A_D1:   return 32'(a_d1);
            A_D2:   return 32'(a_d2);
            A_P1:   return 32'(a_p1);
            A_P2:   return 32'(a_p2);
            A_BUSY: return 32'(a_busy);
            B_D1:   return 32'(b_d1);
            B_P1:   return 32'(b_p1);
            B_BUSY: return 32'(b_busy);
            Z_D1:   return 32'(z_d1);
            Z_P1:   return 32'(z_p1);
            Z_BUSY: return 32'(z_busy);
            W_D1:   return w_d1;
            W_D2:   return w_d2;
            W_BUSY: return 32'(w_busy);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(sig_e s, logic [31:0] v, string tag);
        exp_t e;
        e.sig = s; e.val = v; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic drive(logic vrst, logic vwe, logic [2:0] vwreg, logic [15:0] vwd,
                         logic vres, logic [2:0] vrreg, logic [2:0] vr1, logic [2:0] vr2);
        rst = vrst; we = vwe; wreg = vwreg; wd = vwd;
        res = vres; rreg = vrreg; r1 = vr1; r2 = vr2;
    endtask

    task automatic drive_w(logic vrst, logic vwe, logic [3:0] vwreg, logic [31:0] vwd,
                           logic vres, logic [3:0] vrreg, logic [3:0] vr1, logic [3:0] vr2);
        w_rst = vrst; w_we = vwe; w_wreg = vwreg; w_wd = vwd;
        w_res = vres; w_rreg = vrreg; w_r1 = vr1; w_r2 = vr2;
    endtask

    // Compare queued expectations mid-cycle, then advance past the next rising edge.
    task automatic cycle_end();
        exp_t        e;
        logic [31:0] a;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = actual(e.sig);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.tag, a, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Default instance: reset state, write/read, reset clear, bypass, scoreboard, mid-run reset.
        vecs[0]  = mk(0,0,3'd0,16'h0000,0,3'd0,3'd3,3'd5, 16'h0000,16'h0000,0,0,8'h00);
        vecs[1]  = mk(0,1,3'd3,16'h1234,0,3'd0,3'd0,3'd1, 16'h0000,16'h0000,0,0,8'h00);
        vecs[2]  = mk(0,0,3'd0,16'h0000,0,3'd0,3'd3,3'd3, 16'h1234,16'h1234,0,0,8'h00);
        vecs[3]  = mk(1,1,3'd3,16'h5555,1,3'd3,3'd3,3'd3, 16'h1234,16'h1234,0,0,8'h00);
        vecs[4]  = mk(0,0,3'd0,16'h0000,0,3'd0,3'd3,3'd0, 16'h0000,16'h0000,0,0,8'h00);
        vecs[5]  = mk(0,1,3'd5,16'hBEEF,0,3'd0,3'd0,3'd1, 16'h0000,16'h0000,0,0,8'h00);
        vecs[6]  = mk(0,0,3'd0,16'h0000,0,3'd0,3'd5,3'd5, 16'hBEEF,16'hBEEF,0,0,8'h00);
        vecs[7]  = mk(0,0,3'd0,16'h0000,0,3'd0,3'd0,3'd7, 16'h0000,16'h0000,0,0,8'h00);
        vecs[8]  = mk(0,1,3'd2,16'h0001,0,3'd0,3'd1,3'd4, 16'h0000,16'h0000,0,0,8'h00);
        vecs[9]  = mk(0,1,3'd2,16'h00AA,0,3'd0,3'd2,3'd3, 16'h00AA,16'h0000,0,0,8'h00);
        vecs[10] = mk(0,0,3'd0,16'h0000,0,3'd0,3'd2,3'd2, 16'h00AA,16'h00AA,0,0,8'h00);
        vecs[11] = mk(0,0,3'd0,16'h0000,1,3'd4,3'd4,3'd2, 16'h0000,16'h00AA,0,0,8'h00);
        vecs[12] = mk(0,0,3'd0,16'h0000,0,3'd0,3'd4,3'd4, 16'h0000,16'h0000,1,1,8'h10);
        vecs[13] = mk(0,1,3'd4,16'h0F0F,0,3'd0,3'd4,3'd5, 16'h0F0F,16'hBEEF,0,0,8'h10);
        vecs[14] = mk(0,0,3'd0,16'h0000,0,3'd0,3'd4,3'd4, 16'h0F0F,16'h0F0F,0,0,8'h00);
        vecs[15] = mk(0,0,3'd0,16'h0000,1,3'd4,3'd4,3'd0, 16'h0F0F,16'h0000,0,0,8'h00);
        vecs[16] = mk(0,1,3'd4,16'h1111,1,3'd4,3'd4,3'd6, 16'h1111,16'h0000,0,0,8'h10);
        vecs[17] = mk(0,0,3'd0,16'h0000,0,3'd0,3'd4,3'd4, 16'h1111,16'h1111,1,1,8'h10);
        vecs[18] = mk(0,0,3'd0,16'h0000,1,3'd6,3'd6,3'd4, 16'h0000,16'h1111,0,1,8'h10);
        vecs[19] = mk(1,1,3'd4,16'h9999,0,3'd0,3'd4,3'd6, 16'h1111,16'h0000,1,1,8'h50);
        vecs[20] = mk(0,0,3'd0,16'h0000,0,3'd0,3'd4,3'd6, 16'h0000,16'h0000,0,0,8'h00);

        // Initial reset of every instance (outputs unknown before it, so unchecked).
        drive(1,0,3'd0,16'h0,0,3'd0,3'd0,3'd0);
        drive_w(1,0,4'd0,32'h0,0,4'd0,4'd0,4'd0);
        @(posedge clk);
        #1;
        drive_w(0,0,4'd0,32'h0,0,4'd0,4'd0,4'd0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wreg, vecs[i].wd,
                  vecs[i].res, vecs[i].rreg, vecs[i].r1, vecs[i].r2);
            push(A_D1,   32'(vecs[i].d1),   $sformatf("vec%0d Data1", i));
            push(A_D2,   32'(vecs[i].d2),   $sformatf("vec%0d Data2", i));
            push(A_P1,   32'(vecs[i].p1),   $sformatf("vec%0d Pending1", i));
            push(A_P2,   32'(vecs[i].p2),   $sformatf("vec%0d Pending2", i));
            push(A_BUSY, 32'(vecs[i].busy), $sformatf("vec%0d Busy", i));
            cycle_end();
        end

        // No-bypass instance: reads see stored data only; pending holds until the edge.
        drive(1,0,3'd0,16'h0,0,3'd0,3'd0,3'd0);           cycle_end();
        drive(0,1,3'd2,16'h0001,0,3'd0,3'd0,3'd0);        cycle_end();
        drive(0,1,3'd2,16'h00AA,0,3'd0,3'd2,3'd0);
        push(B_D1, 32'h0001, "nobyp same-cycle Data1");   cycle_end();
        drive(0,0,3'd0,16'h0,1,3'd4,3'd2,3'd0);
        push(B_D1, 32'h00AA, "nobyp next-cycle Data1");
        push(B_P1, 32'h0, "nobyp Pending1 r2");          cycle_end();
        drive(0,1,3'd4,16'h0F0F,0,3'd0,3'd4,3'd0);
        push(B_D1, 32'h0000, "nobyp wb-cycle Data1");
        push(B_P1, 32'h1, "nobyp wb-cycle Pending1");
        push(B_BUSY, 32'h10, "nobyp Busy reserved");     cycle_end();
        drive(0,0,3'd0,16'h0,0,3'd0,3'd4,3'd0);
        push(B_D1, 32'h0F0F, "nobyp after-wb Data1");
        push(B_P1, 32'h0, "nobyp after-wb Pending1");
        push(B_BUSY, 32'h00, "nobyp Busy cleared");      cycle_end();

        // Zero-register instance: r0 ignores writes and reservations.
        drive(1,0,3'd0,16'h0,0,3'd0,3'd0,3'd0);           cycle_end();
        drive(0,1,3'd0,16'hFFFF,1,3'd0,3'd0,3'd0);
        push(Z_D1, 32'h0, "zero r0 write-cycle Data1");
        push(Z_P1, 32'h0, "zero r0 write-cycle Pending1"); cycle_end();
        drive(0,0,3'd0,16'h0,0,3'd0,3'd0,3'd0);
        push(Z_D1, 32'h0, "zero r0 Data1");
        push(Z_P1, 32'h0, "zero r0 Pending1");
        push(Z_BUSY, 32'h0, "zero Busy");                 cycle_end();
        drive(0,1,3'd1,16'hABCD,1,3'd1,3'd1,3'd0);
        push(Z_D1, 32'hABCD, "zero r1 bypass Data1");
        push(Z_P1, 32'h0, "zero r1 bypass Pending1");     cycle_end();
        drive(0,0,3'd0,16'h0,0,3'd0,3'd1,3'd0);
        push(Z_D1, 32'hABCD, "zero r1 Data1");
        push(Z_P1, 32'h1, "zero r1 Pending1");
        push(Z_BUSY, 32'h02, "zero r1 Busy");             cycle_end();

        // Wide instance: 32-bit data, 16 registers, 16-bit Busy.
        drive(0,0,3'd0,16'h0,0,3'd0,3'd0,3'd0);
        drive_w(0,1,4'd15,32'hDEADBEEF,0,4'd0,4'd0,4'd0); cycle_end();
        drive_w(0,1,4'd0,32'h00000001,0,4'd0,4'd15,4'd1);
        push(W_D1, 32'hDEADBEEF, "wide r15 Data1");
        push(W_D2, 32'h0, "wide r1 Data2");               cycle_end();
        drive_w(0,0,4'd0,32'h0,1,4'd15,4'd15,4'd0);
        push(W_D1, 32'hDEADBEEF, "wide r15 readback");
        push(W_D2, 32'h00000001, "wide r0 readback");
        push(W_BUSY, 32'h0, "wide Busy idle");            cycle_end();
        drive_w(0,0,4'd0,32'h0,0,4'd0,4'd15,4'd0);
        push(W_BUSY, 32'h8000, "wide Busy r15");          cycle_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_reg_param.md
Name: banco_reg_param

Overview:
Parametrised register file for the LAOC datapath: NUM_REGS = 2**ADDR_W registers of LARGURA bits, two combinational read ports and one synchronous write port.
Adds synchronous clear, optional write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard.
The scoreboard lets the control unit stall on pending writebacks.
Sits between the decode stage (read addresses, reservation) and the writeback stage (WriteReg/WriteData/RegWrite).

Parameters:
LARGURA, 16, data width in bits (>=1)
ADDR_W, 3, address width; NUM_REGS = 2**ADDR_W registers
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored contents only
ZERO_R0, 0, 1 = register 0 always reads 0, ignores writes and never becomes busy

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears registers and scoreboard
Read1  input  ADDR_W  read address, port 1
Read2  input  ADDR_W  read address, port 2
WriteReg  input  ADDR_W  write address
WriteData  input  LARGURA  write data
RegWrite  input  1  write enable; also clears the busy bit of WriteReg
Reserve  input  1  marks ReserveReg as pending a future write
ReserveReg  input  ADDR_W  register being reserved
Data1  output  LARGURA  read data, port 1
Data2  output  LARGURA  read data, port 2
Pending1  output  1  the Data1 value is stale (a write is outstanding)
Pending2  output  1  the Data2 value is stale
Busy  output  NUM_REGS  scoreboard vector; bit i = register i pending

Behaviour:
- One clock; reset is synchronous and active-high. At the first rising edge with reset=1:
  - all registers = 0; Busy = 0.
  - RegWrite and Reserve are ignored on that edge.
  - After that edge, Data1 = Data2 = 0 and Pending1 = Pending2 = 0 for any address.
- Write: at a rising edge with reset=0 and RegWrite=1, mem[WriteReg] <= WriteData. The stored value is visible on the read ports from the next cycle.
- Write is suppressed when ZERO_R0=1 and WriteReg=0.
- Read: combinational, zero latency, Data1 = mem[Read1] and Data2 = mem[Read2].
- Bypass hit on port k: BYPASS=1, reset=0, RegWrite=1, WriteReg=Readk, and the write is not suppressed.
  - On a hit, Datak = WriteData in the same cycle.
- Zero register: with ZERO_R0=1 and Readk=0, Datak = 0 and Pendingk = 0, regardless of bypass.
- Both ports may address the same register. Each port resolves independently and identically.
- Scoreboard update at a rising edge with reset=0, evaluated per bit i:
  - Reserve=1 and ReserveReg=i: busy[i] <= 1.
  - Otherwise, RegWrite=1 and WriteReg=i: busy[i] <= 0.
  - Otherwise, busy[i] holds.
  - Simultaneous reserve and write to the same register: reserve wins, so busy stays or becomes 1 (a new producer was issued).
  - Reserving an already-busy register keeps it at 1. No counting; one outstanding write per register.
  - A write to a non-busy register is legal: data is stored and busy stays 0.
- ZERO_R0=1: Reserve of register 0 is ignored, so busy[0] is constantly 0.
- Pendingk = busy[Readk] AND NOT bypass-hit on port k.
  - A writeback in the current cycle satisfies the reader immediately when BYPASS=1.
  - With BYPASS=0, Pendingk stays 1 until the edge that clears the busy bit.
- Reset asserted mid-sequence, while registers are busy or a write is presented: reset has priority. All state is cleared and the in-flight write is lost.
- Address width rule: all addresses index exactly NUM_REGS entries. There is no out-of-range case and no wrap logic.
- Data width rule: no truncation or extension; WriteData is stored exactly as LARGURA bits.

Test Plan:
- Reset clear: write 0x1234 to r3, assert reset for 1 cycle, deassert -> Data1(Read1=3) = 0x0000 and Busy = 8'h00.
- Basic write/read: RegWrite=1, WriteReg=5, WriteData=0xBEEF, then idle; Read1=5, Read2=5 -> Data1 = Data2 = 0xBEEF next cycle. No other register changed (all read 0).
- Bypass:
  - BYPASS=1: mem[2] = 0x0001, present RegWrite=1, WriteReg=2, WriteData=0x00AA with Read1=2 -> Data1 = 0x00AA in the same cycle; Read2=3 is unaffected.
  - BYPASS=0: same stimulus -> Data1 = 0x0001 that cycle and 0x00AA the next.
- Scoreboard:
  - Reserve r4 -> Busy[4]=1 and Pending1=1 with Read1=4.
  - Writeback r4 = 0x0F0F with BYPASS=1 -> Pending1=0 and Data1 = 0x0F0F that cycle; Busy[4]=0 after the edge.
  - Same-cycle Reserve r4 + RegWrite r4 -> Busy[4] remains 1.
- Zero register (ZERO_R0=1): write 0xFFFF to r0 and Reserve r0 -> Data1(Read1=0) = 0x0000, Busy[0]=0, Pending1=0.
- Parametrised instance (LARGURA=32, ADDR_W=4): write 0xDEADBEEF to r15 and 0x1 to r0 -> both read back exactly; Busy is 16 bits wide.
